// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// Data has priority. A global stall holds the pipeline until every access
// needed this step has completed. A timeout aborts a hung access and sets a
// sticky bus error. A free-running counter tallies stalled cycles.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic [31:0]      mem_rdata,
  output logic             m_req,
  output logic             m_we,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_ready,
  input  logic [31:0]      m_rdata,
  output logic             stall,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_INST} owner_t;

  // The abort fires in the cycle where the wait count would reach TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  owner_t           r_owner, w_sel, w_owner_nxt;
  logic             r_d_served, r_i_served;
  logic [31:0]      r_if_lat, r_mem_lat;
  logic [15:0]      r_tcnt;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_stall_cycles;

  logic        w_d_need, w_i_need, w_req, w_tmo, w_done;
  logic        w_d_comp, w_i_comp, w_d_load_comp, w_stall;
  logic [31:0] w_cdata;

  assign w_d_need = mem_rd | mem_wr;
  assign w_i_need = if_req;

  // Owner selection (zero-wait issue from NONE) and next-owner decision.
  always_comb begin
    w_sel = r_owner;
    if (r_owner == OWN_NONE) begin
      if (w_d_need && !r_d_served)      w_sel = OWN_DATA;
      else if (w_i_need && !r_i_served) w_sel = OWN_INST;
    end
    w_owner_nxt = (w_req && !w_done) ? w_sel : OWN_NONE;
  end

  assign w_req    = !reset && (w_sel != OWN_NONE);
  assign w_tmo    = w_req && !m_ready && (r_tcnt == TMO_LAST);
  assign w_done   = w_req && (m_ready || w_tmo);
  assign w_d_comp = w_done && (w_sel == OWN_DATA);
  assign w_i_comp = w_done && (w_sel == OWN_INST);
  // A store with mem_rd also set is still a store: nothing to capture.
  assign w_d_load_comp = w_d_comp && !mem_wr;
  assign w_cdata  = w_tmo ? 32'h0 : m_rdata;

  assign w_stall = !reset &&
                   ((w_d_need && !r_d_served && !w_d_comp) ||
                    (w_i_need && !r_i_served && !w_i_comp));

  assign m_req   = w_req;
  assign m_we    = w_req && (w_sel == OWN_DATA) && mem_wr;
  assign m_addr  = (w_sel == OWN_DATA) ? mem_addr : if_addr;
  assign m_wdata = (w_sel == OWN_DATA) ? mem_wdata : 32'h0;

  assign mem_rdata    = w_d_load_comp ? w_cdata : r_mem_lat;
  assign if_rdata     = w_i_comp ? w_cdata : r_if_lat;
  assign stall        = w_stall;
  assign bus_err      = r_bus_err;
  assign stall_cycles = r_stall_cycles;

  // Owner register: holds the selection while an access waits on m_ready.
  always_ff @(posedge clk) begin
    if (reset) r_owner <= OWN_NONE;
    else       r_owner <= w_owner_nxt;
  end

  // Served flags: set on completion, cleared whenever the pipeline advances.
  always_ff @(posedge clk) begin
    if (reset || !w_stall) begin
      r_d_served <= 1'b0;
      r_i_served <= 1'b0;
    end else begin
      if (w_d_comp) r_d_served <= 1'b1;
      if (w_i_comp) r_i_served <= 1'b1;
    end
  end

  // Read-data latches: hold the last completed read of each port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_lat <= 32'h0;
      r_if_lat  <= 32'h0;
    end else begin
      if (w_d_load_comp) r_mem_lat <= w_cdata;
      if (w_i_comp)      r_if_lat  <= w_cdata;
    end
  end

  // Wait counter: counts waiting cycles of the current access.
  always_ff @(posedge clk) begin
    if (reset || w_done || !w_req) r_tcnt <= 16'h0;
    else if (!m_ready)             r_tcnt <= r_tcnt + 16'h1;
  end

  // Sticky bus error and wrapping stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_tmo)   r_bus_err      <= 1'b1;
      if (w_stall) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A transaction-level model predicts each cycle:
// the needed accesses run back to back in priority order (data then fetch),
// each lasting (waits+1) cycles, or TMO cycles when the memory never answers.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk, reset;
  logic        if_req, mem_rd, mem_wr, m_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, m_rdata;
  logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
  logic        m_req, m_we, stall, bus_err;
  logic [31:0] stall_cycles;

  mem_port_arbiter #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .stall(stall), .bus_err(bus_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state
  logic [31:0] lat_d, lat_i, mdl_sc;
  logic        mdl_berr;
  // Per-cycle expectations
  logic        chk_en;
  logic        exp_mreq, exp_we, exp_stall, exp_berr;
  logic [31:0] exp_maddr, exp_wdata, exp_mrd, exp_ird, exp_sc;

  // Recorded DUT outputs of the current step, for literal checks
  logic [31:0] rec_maddr[16], rec_mrd[16], rec_ird[16];
  logic        rec_mreq[16], rec_we[16], rec_stall[16], rec_berr[16];
  logic [31:0] sc_start, sc_end;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_req", {31'h0, m_req}, {31'h0, exp_mreq});
      if (exp_mreq) begin
        cmp("m_addr", m_addr, exp_maddr);
        cmp("m_we", {31'h0, m_we}, {31'h0, exp_we});
        if (exp_we) cmp("m_wdata", m_wdata, exp_wdata);
      end
      cmp("stall", {31'h0, stall}, {31'h0, exp_stall});
      cmp("mem_rdata", mem_rdata, exp_mrd);
      cmp("if_rdata", if_rdata, exp_ird);
      cmp("bus_err", {31'h0, bus_err}, {31'h0, exp_berr});
      cmp("stall_cycles", stall_cycles, exp_sc);
    end
  end

  // dk: 0 none, 1 load, 2 store, 3 rd+wr (store). w: memory wait states.
  task automatic run_step(input int dk, input bit in, input logic [31:0] ia,
                          input logic [31:0] da, input logic [31:0] wd,
                          input logic [31:0] rd, input int w, input int maxc);
    int n, dur, j, p;
    bit isd, comp, ab;
    logic [31:0] cd;
    mem_rd = (dk == 1 || dk == 3);
    mem_wr = (dk >= 2);
    if_req = in;
    if_addr = ia; mem_addr = da; mem_wdata = wd;
    n = ((dk != 0) ? 1 : 0) + (in ? 1 : 0);
    ab = (w >= TMO);
    dur = ab ? TMO : w + 1;
    for (int k = 0; k < maxc; k++) begin
      j = k / dur;
      p = k % dur;
      isd = (dk != 0) && (j == 0);
      comp = (j < n) && (p == dur - 1);
      cd = ab ? 32'h0 : rd + 32'(k);
      m_rdata = rd + 32'(k);
      m_ready = (j < n) && !ab && (p == w);
      exp_mreq = (j < n);
      exp_maddr = isd ? da : ia;
      exp_we = isd && (dk >= 2);
      exp_wdata = wd;
      exp_stall = (k < n * dur - 1);
      exp_mrd = (comp && isd && dk == 1) ? cd : lat_d;
      exp_ird = (comp && !isd) ? cd : lat_i;
      exp_berr = mdl_berr;
      exp_sc = mdl_sc;
      @(negedge clk);
      if (k < 16) begin
        rec_maddr[k] = m_addr; rec_mrd[k] = mem_rdata; rec_ird[k] = if_rdata;
        rec_mreq[k] = m_req; rec_we[k] = m_we; rec_stall[k] = stall;
        rec_berr[k] = bus_err;
      end
      if (k == 0) sc_start = stall_cycles;
      @(posedge clk);
      if (exp_stall) mdl_sc = mdl_sc + 32'h1;
      if (comp && isd && dk == 1) lat_d = cd;
      if (comp && !isd) lat_i = cd;
      if (comp && ab) mdl_berr = 1'b1;
      #1;
      if (!exp_stall) break;
    end
    sc_end = stall_cycles;
  endtask

  task automatic idle();
    run_step(0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
  endtask

  initial begin
    chk_en = 1'b0;
    reset = 1'b1;
    if_req = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    m_ready = 1'b1; m_rdata = 32'h9999_9999;
    lat_d = 32'h0; lat_i = 32'h0; mdl_sc = 32'h0; mdl_berr = 1'b0;

    // Reset: requests present but nothing may be issued or stalled
    @(negedge clk);
    cmp("rst m_req", {31'h0, m_req}, 32'h0);
    cmp("rst stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst stall_cycles", stall_cycles, 32'h0);
    cmp("rst bus_err", {31'h0, bus_err}, 32'h0);
    cmp("rst mem_rdata", mem_rdata, 32'h0);
    cmp("rst if_rdata", if_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b0; mem_rd = 1'b0;
    chk_en = 1'b1;

    // Load only, zero-wait
    run_step(1, 1'b0, 32'h0, 32'h40, 32'h0, 32'h1234_5678, 0, 16);
    cmp("t1 m_req", {31'h0, rec_mreq[0]}, 32'h1);
    cmp("t1 m_we", {31'h0, rec_we[0]}, 32'h0);
    cmp("t1 m_addr", rec_maddr[0], 32'h40);
    cmp("t1 stall", {31'h0, rec_stall[0]}, 32'h0);
    cmp("t1 mem_rdata", rec_mrd[0], 32'h1234_5678);

    // Fetch + store, zero-wait
    run_step(2, 1'b1, 32'h100, 32'h200, 32'hDEAD_BEEF, 32'h0A00_0000, 0, 16);
    cmp("t2 c0 m_addr", rec_maddr[0], 32'h200);
    cmp("t2 c0 m_we", {31'h0, rec_we[0]}, 32'h1);
    cmp("t2 c0 stall", {31'h0, rec_stall[0]}, 32'h1);
    cmp("t2 c1 m_addr", rec_maddr[1], 32'h100);
    cmp("t2 c1 m_we", {31'h0, rec_we[1]}, 32'h0);
    cmp("t2 c1 stall", {31'h0, rec_stall[1]}, 32'h0);
    cmp("t2 c1 if_rdata", rec_ird[1], 32'h0A00_0001);
    cmp("t2 stall delta", sc_end - sc_start, 32'h1);
    idle();

    // Load with 3 wait states
    run_step(1, 1'b0, 32'h0, 32'h44, 32'h0, 32'h0B00_0000, 3, 16);
    cmp("t3 c0 stall", {31'h0, rec_stall[0]}, 32'h1);
    cmp("t3 c2 stall", {31'h0, rec_stall[2]}, 32'h1);
    cmp("t3 c2 m_addr", rec_maddr[2], 32'h44);
    cmp("t3 c3 stall", {31'h0, rec_stall[3]}, 32'h0);
    cmp("t3 c3 mem_rdata", rec_mrd[3], 32'h0B00_0003);
    cmp("t3 stall delta", sc_end - sc_start, 32'h3);

    // Fetch + load, 2 wait states each
    run_step(1, 1'b1, 32'h300, 32'h48, 32'h0, 32'h0C00_0000, 2, 16);
    cmp("t4 c2 mem_rdata", rec_mrd[2], 32'h0C00_0002);
    cmp("t4 c3 m_addr", rec_maddr[3], 32'h300);
    cmp("t4 c4 stall", {31'h0, rec_stall[4]}, 32'h1);
    cmp("t4 c5 stall", {31'h0, rec_stall[5]}, 32'h0);
    cmp("t4 c5 mem_rdata", rec_mrd[5], 32'h0C00_0002);
    cmp("t4 c5 if_rdata", rec_ird[5], 32'h0C00_0005);
    cmp("t4 stall delta", sc_end - sc_start, 32'h5);

    // rd+wr together is a store; fetch follows; 1 wait state
    run_step(3, 1'b1, 32'h304, 32'h50, 32'h55AA_55AA, 32'h0D00_0000, 1, 16);
    cmp("t5 c0 m_we", {31'h0, rec_we[0]}, 32'h1);
    cmp("t5 c3 if_rdata", rec_ird[3], 32'h0D00_0003);
    cmp("t5 c3 mem_rdata", rec_mrd[3], 32'h0C00_0002);
    cmp("t5 stall delta", sc_end - sc_start, 32'h3);

    // Load against a memory that never answers: timeout abort
    run_step(1, 1'b0, 32'h0, 32'h60, 32'h0, 32'h0E00_0000, 100, 16);
    cmp("t6 c3 m_req", {31'h0, rec_mreq[3]}, 32'h1);
    cmp("t6 c3 stall", {31'h0, rec_stall[3]}, 32'h0);
    cmp("t6 c3 mem_rdata", rec_mrd[3], 32'h0);
    cmp("t6 c3 bus_err", {31'h0, rec_berr[3]}, 32'h0);
    idle();
    cmp("t6 next m_req", {31'h0, rec_mreq[0]}, 32'h0);
    cmp("t6 next bus_err", {31'h0, rec_berr[0]}, 32'h1);

    // Reset while a fetch is waiting
    run_step(0, 1'b1, 32'h400, 32'h0, 32'h0, 32'h0F00_0000, 3, 2);
    chk_en = 1'b0;
    reset = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    cmp("t7 rst m_req", {31'h0, m_req}, 32'h0);
    cmp("t7 rst stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b0;
    lat_d = 32'h0; lat_i = 32'h0; mdl_sc = 32'h0; mdl_berr = 1'b0;
    @(negedge clk);
    cmp("t7 m_req", {31'h0, m_req}, 32'h0);
    cmp("t7 stall_cycles", stall_cycles, 32'h0);
    cmp("t7 bus_err", {31'h0, bus_err}, 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Fetch only after reset, zero-wait
    run_step(0, 1'b1, 32'h404, 32'h0, 32'h0, 32'h1000_0000, 0, 16);
    cmp("t8 stall", {31'h0, rec_stall[0]}, 32'h0);
    cmp("t8 if_rdata", rec_ird[0], 32'h1000_0000);
    cmp("t8 stall delta", sc_end - sc_start, 32'h0);
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
